// File: rtl/uart_pia_pkg.sv
// uart_pia_pkg: shared constants and TX state encoding for the Apple-1 style PIA bridge.
// Rev 1.0
`default_nettype none

package uart_pia_pkg;

  localparam logic [1:0] KBD   = 2'd0;
  localparam logic [1:0] KBDCR = 2'd1;
  localparam logic [1:0] DSP   = 2'd2;
  localparam logic [1:0] DSPCR = 2'd3;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_WAIT_HI = 3'd1,
    TX_WAIT_LO = 3'd2,
    TX_SEND_LF = 3'd3,
    TX_WAIT_LF = 3'd4
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with wrap-bit pointers; a pop frees room for a same-cycle push.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_pia_ctrl.sv
// uart_pia_ctrl: KBD/KBDCR/DSP/DSPCR register bridge between the CPU bus and a UART RX/TX pair.
// Rev 1.0
`default_nettype none

module uart_pia_ctrl
  import uart_pia_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter bit UPCASE   = 1'b1,
  parameter bit CRLF     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       rx_pending
);

  function automatic logic [7:0] conv(input logic [7:0] b);
    if (UPCASE && (b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
    return b;
  endfunction

  logic       w_kbd_rd;
  logic       w_kbdcr_rd;
  logic       w_dsp_wr;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_head;
  logic       w_ovf_evt;

  logic       overflow_q;
  tx_state_e  state_q;
  logic [7:0] hold_q;
  logic       hold_valid_q;
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  logic       lf_seen_q;

  assign w_kbd_rd   = cpu_en & ~cpu_we & (cpu_addr == KBD);
  assign w_kbdcr_rd = cpu_en & ~cpu_we & (cpu_addr == KBDCR);
  assign w_dsp_wr   = cpu_en &  cpu_we & (cpu_addr == DSP);

  // A byte is lost only when the FIFO is full and no pop frees a slot this cycle.
  assign w_ovf_evt = rx_ready & w_fifo_full & ~(w_kbd_rd & ~w_fifo_empty);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (rx_ready),
    .pop_i  (w_kbd_rd),
    .din_i  (conv(rx_data)),
    .full_o (w_fifo_full),
    .empty_o(w_fifo_empty),
    .head_o (w_head)
  );

  always_comb begin
    cpu_dout = 8'h00;
    case (cpu_addr)
      KBD:     cpu_dout = w_head | 8'h80;
      KBDCR:   cpu_dout = {~w_fifo_empty, 6'b0, overflow_q};
      DSP:     cpu_dout = {hold_valid_q, 7'b0};
      default: cpu_dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow_q <= 1'b0;
    else if (w_ovf_evt)     overflow_q <= 1'b1;
    else if (w_kbdcr_rd)    overflow_q <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= TX_IDLE;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      lf_seen_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (w_dsp_wr && !hold_valid_q) begin
        hold_q       <= cpu_din & 8'h7F;
        hold_valid_q <= 1'b1;
      end
      case (state_q)
        TX_IDLE: begin
          if (hold_valid_q && !tx_busy) begin
            tx_data_q  <= hold_q;
            tx_start_q <= 1'b1;
            state_q    <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (tx_busy) state_q <= TX_WAIT_LO;
        end
        TX_WAIT_LO: begin
          if (!tx_busy) begin
            if (CRLF && (hold_q == CHAR_CR)) begin
              state_q <= TX_SEND_LF;
            end else begin
              hold_valid_q <= 1'b0;
              state_q      <= TX_IDLE;
            end
          end
        end
        TX_SEND_LF: begin
          tx_data_q  <= CHAR_LF;
          tx_start_q <= 1'b1;
          lf_seen_q  <= 1'b0;
          state_q    <= TX_WAIT_LF;
        end
        TX_WAIT_LF: begin
          if (!lf_seen_q) begin
            if (tx_busy) lf_seen_q <= 1'b1;
          end else if (!tx_busy) begin
            lf_seen_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            state_q      <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign rx_pending = ~w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_pia_ctrl.sv
// tb_uart_pia_ctrl: scoreboard bench; CRLF=1 main instance plus a CRLF=0 shadow instance on the same bus.
// Rev 1.0
`default_nettype none

module tb_uart_pia_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_en = 1'b0;
  logic       cpu_we = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic [7:0] cpu_din = 8'h00;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;

  logic [7:0] dout1, txd1, dout2, txd2;
  logic       txs1, pend1, txs2, pend2;
  logic       busy1, busy2;
  int         cnt1, cnt2;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] st1 = 8'd0;
  logic [7:0] st2 = 8'd0;
  logic [7:0] last2 = 8'h00;

  logic [7:0] rd_q[$];
  string      rd_nm_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  uart_pia_ctrl #(.RX_DEPTH(4), .UPCASE(1'b1), .CRLF(1'b1)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(dout1), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(txd1), .tx_start(txs1), .tx_busy(busy1), .rx_pending(pend1)
  );

  uart_pia_ctrl #(.RX_DEPTH(4), .UPCASE(1'b1), .CRLF(1'b0)) dut_nocrlf (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(dout2), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(txd2), .tx_start(txs2), .tx_busy(busy2), .rx_pending(pend2)
  );

  // Transmitter model: busy rises the edge after a start and stays up for six clocks.
  always @(posedge clk or posedge reset) begin
    if (reset)          cnt1 <= 0;
    else if (txs1)      cnt1 <= 6;
    else if (cnt1 != 0) cnt1 <= cnt1 - 1;
  end
  always @(posedge clk or posedge reset) begin
    if (reset)          cnt2 <= 0;
    else if (txs2)      cnt2 <= 6;
    else if (cnt2 != 0) cnt2 <= cnt2 - 1;
  end
  assign busy1 = (cnt1 != 0);
  assign busy2 = (cnt2 != 0);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a TX start.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_en && !cpu_we) begin
        if (rd_q.size() == 0) fail_now("unexpected_read");
        else chk(rd_nm_q.pop_front(), dout1, rd_q.pop_front());
      end
      if (txs1) begin
        st1 = st1 + 8'd1;
        if (tx_q.size() == 0) fail_now("unexpected_tx_start");
        else chk("tx_data", txd1, tx_q.pop_front());
      end
      if (txs2) begin
        st2 = st2 + 8'd1;
        last2 = txd2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    rd_q.push_back(e); rd_nm_q.push_back(nm);
    tick();
    cpu_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick();
    cpu_en = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic rx_rd(input logic [7:0] b, input logic [7:0] e, input string nm);
    rx_ready = 1'b1; rx_data = b;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd0;
    rd_q.push_back(e); rd_nm_q.push_back(nm);
    tick();
    rx_ready = 1'b0; cpu_en = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy1 || txs1) quiet = 0;
      else quiet++;
      if (quiet >= 5) return;
    end
    fail_now("wait_idle_timeout");
  endtask

  task automatic wait_starts(input logic [7:0] n);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (st1 >= n) return;
    end
    fail_now("wait_starts_timeout");
  endtask

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_start", {7'b0, txs1}, 8'h00);
    chk("reset_rx_pending", {7'b0, pend1}, 8'h00);
    chk("reset_tx_data", txd1, 8'h00);
    reset = 1'b0;
    tick();
    rd(2'd1, 8'h00, "reset_kbdcr");
    rd(2'd2, 8'h00, "reset_dsp");

    // Single lowercase character is upcased.
    rx(8'h61);
    rd(2'd1, 8'h80, "a_kbdcr");
    rd(2'd0, 8'hC1, "a_kbd");
    rd(2'd1, 8'h00, "a_kbdcr_after");

    // Overflow: fifth byte dropped, first four kept in order.
    for (int i = 0; i < 5; i++) rx(8'h31 + 8'(i));
    rd(2'd1, 8'h81, "ovf_kbdcr");
    for (int i = 0; i < 4; i++) rd(2'd0, 8'hB1 + 8'(i), "ovf_kbd");
    rd(2'd1, 8'h00, "ovf_kbdcr_cleared");

    // Upcase range boundaries.
    rx(8'h60); rx(8'h7A); rx(8'h7B);
    rd(2'd0, 8'hE0, "conv_60");
    rd(2'd0, 8'hDA, "conv_7A");
    rd(2'd0, 8'hFB, "conv_7B");

    // Push and pop together at count 2.
    rx(8'h41); rx(8'h42);
    rx_rd(8'h43, 8'hC1, "pp2_kbd");
    chk("pp2_pending", {7'b0, pend1}, 8'h01);
    rd(2'd1, 8'h80, "pp2_kbdcr");
    rd(2'd0, 8'hC2, "pp2_kbd2");
    rd(2'd0, 8'hC3, "pp2_kbd3");
    rd(2'd1, 8'h00, "pp2_kbdcr_empty");

    // Push and pop together on a full FIFO.
    for (int i = 0; i < 4; i++) rx(8'h61 + 8'(i));
    rx_rd(8'h65, 8'hC1, "full_pp_kbd");
    rd(2'd1, 8'h80, "full_pp_kbdcr");
    for (int i = 0; i < 4; i++) rd(2'd0, 8'hC2 + 8'(i), "full_pp_order");
    rd(2'd1, 8'h00, "full_pp_kbdcr_empty");

    // Plain character through the transmitter.
    tx_q.push_back(8'h41);
    wr(2'd2, 8'h41);
    chk("dsp_no_early_start", {7'b0, txs1}, 8'h00);
    tick();
    chk("dsp_latency_start", {7'b0, txs1}, 8'h01);
    rd(2'd2, 8'h80, "dsp_busy");
    wr(2'd2, 8'h42);
    rd(2'd2, 8'h80, "dsp_busy2");
    wait_idle();
    rd(2'd2, 8'h00, "dsp_done");
    chk("dsp_start_count", st1, 8'd1);

    // CR expands to CR+LF on the main instance only.
    tx_q.push_back(8'h0D);
    tx_q.push_back(8'h0A);
    wr(2'd2, 8'h0D);
    wait_starts(8'd2);
    rd(2'd2, 8'h80, "cr_busy_mid");
    wait_starts(8'd3);
    cpu_addr = 2'd2;
    #1;
    chk("nocrlf_dsp_done", dout2, 8'h00);
    rd(2'd2, 8'h80, "cr_busy_lf");
    wait_idle();
    rd(2'd2, 8'h00, "cr_done");
    chk("nocrlf_start_count", st2, 8'd2);
    chk("nocrlf_last_data", last2, 8'h0D);

    // Reset in the middle of a CR+LF with a byte pending.
    rx(8'h41);
    chk("pre_reset_pending", {7'b0, pend1}, 8'h01);
    wr(2'd2, 8'h0D);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = txs1;
    end
    if (!seen) fail_now("midreset_no_start");
    reset = 1'b1;
    #1;
    chk("midreset_tx_start", {7'b0, txs1}, 8'h00);
    chk("midreset_pending", {7'b0, pend1}, 8'h00);
    chk("midreset_pending2", {7'b0, pend2}, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick();
    rd(2'd1, 8'h00, "midreset_kbdcr");
    rd(2'd2, 8'h00, "midreset_dsp");
    repeat (20) tick();
    chk("midreset_no_lf", st1, 8'd3);

    chk("rd_q_drained", 8'(rd_q.size()), 8'd0);
    chk("tx_q_drained", 8'(tx_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
